// File: rtl/ctl_seq.sv
// rtl/ctl_seq.sv - fetch/execute control sequencer for a four-instruction accumulator machine
// Drives a single memory bus (stb/ack handshake) and the accumulator datapath controls.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 2
`endif
`ifndef OP_NOR
`define OP_NOR 2'd0
`endif
`ifndef OP_ADD
`define OP_ADD 2'd1
`endif
`ifndef OP_STA
`define OP_STA 2'd2
`endif
`ifndef OP_JCC
`define OP_JCC 2'd3
`endif
`ifndef CTR_CARRYMUX_WIDTH
`define CTR_CARRYMUX_WIDTH 2
`endif
`ifndef CARRY_OP_KEEP
`define CARRY_OP_KEEP 2'd0
`endif
`ifndef CARRY_OP_GEN
`define CARRY_OP_GEN 2'd1
`endif
`ifndef CARRY_OP_CLR
`define CARRY_OP_CLR 2'd2
`endif

module ctl_seq #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = DATA_WIDTH - 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_WIDTH-1:0]          mem_dat_i,
  input  logic                           mem_ack_i,
  input  logic                           carry_i,
  output logic                           mem_stb_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_adr_o,
  output logic [`OP_WIDTH-1:0]           ctr_aluop_o,
  output logic                           ctr_a_reg_en_o,
  output logic [`CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_o,
  output logic                           halt_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] OPC_NOR = 2'b00;
  localparam logic [1:0] OPC_ADD = 2'b01;
  localparam logic [1:0] OPC_STA = 2'b10;
  localparam logic [1:0] OPC_JCC = 2'b11;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] w_ir_nxt;

  logic [1:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_ir_adr;
  logic [ADDR_WIDTH-1:0] w_fetch_adr;

  assign w_opcode    = r_ir[DATA_WIDTH-1:DATA_WIDTH-2];
  assign w_ir_adr    = r_ir[ADDR_WIDTH-1:0];
  // PC was already advanced during fetch, so the JCC's own address is PC-1.
  assign w_fetch_adr = r_pc - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    mem_stb_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_adr_o      = r_pc;
    ctr_aluop_o    = `OP_STA;
    ctr_a_reg_en_o = 1'b0;
    ctr_carrymux_o = `CARRY_OP_KEEP;

    case (r_state)
      S_FETCH: begin
        mem_stb_o = 1'b1;
        if (mem_ack_i) begin
          w_ir_nxt    = mem_dat_i;
          w_pc_nxt    = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        case (w_opcode)
          OPC_NOR, OPC_ADD: begin
            ctr_aluop_o = (w_opcode == OPC_ADD) ? `OP_ADD : `OP_NOR;
            mem_stb_o   = 1'b1;
            mem_adr_o   = w_ir_adr;
            if (mem_ack_i) begin
              ctr_a_reg_en_o = 1'b1;
              if (w_opcode == OPC_ADD) begin
                ctr_carrymux_o = `CARRY_OP_GEN;
              end
              w_state_nxt = S_FETCH;
            end
          end
          OPC_STA: begin
            ctr_aluop_o = `OP_STA;
            mem_stb_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_adr_o   = w_ir_adr;
            if (mem_ack_i) begin
              w_state_nxt = S_FETCH;
            end
          end
          default: begin
            ctr_aluop_o    = `OP_JCC;
            ctr_carrymux_o = `CARRY_OP_CLR;
            w_state_nxt    = S_FETCH;
            if (!carry_i) begin
              w_pc_nxt = w_ir_adr;
              // A taken jump onto itself can never make progress: stop.
              if (w_ir_adr == w_fetch_adr) begin
                w_state_nxt = S_HALT;
              end
            end
          end
        endcase
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Reset kills any in-flight transfer in the same cycle.
    if (rst_i) begin
      mem_stb_o      = 1'b0;
      mem_we_o       = 1'b0;
      ctr_a_reg_en_o = 1'b0;
      ctr_carrymux_o = `CARRY_OP_KEEP;
    end
  end

  assign halt_o = (r_state == S_HALT) && !rst_i;

endmodule
